// File: rtl/rr_encoder4_if.sv
// rr_encoder4_if: request/code handshake bundle for rr_encoder4.
// master drives requests and ready; slave presents the code.
interface rr_encoder4_if;
    logic [3:0] Request;
    logic       Disable;
    logic       Ready;
    logic [1:0] Code;
    logic       Valid;
    logic       Overrun;
    logic       Busy;

    modport master (
        output Request,
        output Disable,
        output Ready,
        input  Code,
        input  Valid,
        input  Overrun,
        input  Busy
    );

    modport slave (
        input  Request,
        input  Disable,
        input  Ready,
        output Code,
        output Valid,
        output Overrun,
        output Busy
    );
endinterface

// File: rtl/rr_encoder4.sv
// rr_encoder4: latches four request lines and emits them one at a time
// as a 2-bit code, round-robin, over a valid/ready handshake.
module rr_encoder4 #(
    parameter int    UUID = 0,
    parameter string NAME = ""
) (
    input  logic          clk,
    input  logic          rst,
    rr_encoder4_if.slave  bus
);

    if (UUID < 0) begin : g_uuid_chk
        $error("rr_encoder4 %s: UUID must be non-negative", NAME);
    end

    logic [3:0] pending_q;
    logic [3:0] pending_d;
    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [1:0] code_q;
    logic [1:0] code_d;
    logic       valid_q;
    logic       valid_d;
    logic       overrun_q;
    logic       overrun_d;

    logic [3:0] cand;
    logic       slot_free;
    logic       load;
    logic [1:0] sel;
    logic       found;
    logic [1:0] idx;

    assign cand      = pending_q | bus.Request;
    assign slot_free = !valid_q | bus.Ready;
    assign load      = slot_free & !bus.Disable & (cand != 4'b0000);

    // Round-robin pick: first set candidate scanning up from ptr, wrapping.
    always_comb begin
        sel   = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && cand[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Next-state: load a new code, retire an accepted one, or hold.
    always_comb begin
        pending_d = cand;
        ptr_d     = ptr_q;
        code_d    = code_q;
        valid_d   = valid_q;
        overrun_d = |(bus.Request & pending_q);
        if (load) begin
            code_d    = sel;
            valid_d   = 1'b1;
            ptr_d     = sel + 2'd1;
            pending_d = cand & ~(4'b0001 << sel);
        end else if (valid_q && bus.Ready) begin
            valid_d   = 1'b0;
        end
    end

    // State registers; reset drops any presented code immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 4'b0000;
            ptr_q     <= 2'd0;
            code_q    <= 2'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.Code    = code_q;
    assign bus.Valid   = valid_q;
    assign bus.Overrun = overrun_q;
    assign bus.Busy    = (pending_q != 4'b0000) | valid_q;

endmodule

// File: doc/rr_encoder4.md
Name: rr_encoder4

Overview:
- Request-side counterpart of the team's 2-to-4 decoder with disable: collects four 1-bit request lines and emits them, one at a time, as a 2-bit code with a valid/ready handshake.
- A request held by the decoder side is never lost while it waits; it stays latched until it is emitted.
- Service order is round-robin, so no line can starve.
- Sits between event/request sources and any consumer that takes a 2-bit index, such as a DEC2-driven select path.

Parameters:
- UUID, 0, instance identifier, passed through only.
- NAME, "", instance label, passed through only.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- Request  in  4  request lines; bit i high in a cycle means one request on line i.
- Disable  in  1  when high, no new code is loaded into the output stage. Requests are still latched.
- Ready  in  1  consumer accepts the code this cycle when Valid is also high.
- Code  out  2  index of the request being presented.
- Valid  out  1  Code is meaningful and is held until accepted.
- Overrun  out  1  one-cycle pulse: a request arrived on a line that already had an unserved pending request.
- Busy  out  1  high when any pending bit is set or Valid is high.

Behaviour:
- State:
  - pending[3:0]: latched requests not yet loaded into the output stage.
  - ptr[1:0]: round-robin start position.
  - Output registers: Code, Valid, Overrun.
- Reset (rst=1, async): pending=0, ptr=0, Code=0, Valid=0, Overrun=0, Busy=0. This takes effect mid-handshake too: a presented code is dropped, not completed.
- Definitions:
  - slot_free = !Valid | (Valid & Ready).
  - cand = pending | Request.
  - load = slot_free & !Disable & (cand != 0).
- Selection:
  - Scan cand starting at index ptr, then ptr+1, ptr+2, ptr+3, all mod 4 (wrap 3 -> 0).
  - The first set bit is sel.
- On each rising edge:
  - If load: Code <= sel, Valid <= 1, ptr <= sel+1 mod 4, pending <= cand & ~onehot(sel).
  - Else if Valid & Ready (accepted but nothing loaded): Valid <= 0, Code holds, pending <= cand.
  - Else: Valid and Code hold, pending <= cand.
  - Overrun <= |(Request & pending), using pending before the update.
  - A request that collides with its own pending bit counts as one request.
- Latency: a request sampled with an empty output stage and Disable=0 gives Valid=1 and the matching Code on the next edge (1 cycle).
- Throughput: back-to-back. With Ready held high and requests pending, one code is emitted per cycle.
- Handshake:
  - Code and Valid are stable while Valid=1 & Ready=0.
  - Ready while Valid=0 has no effect.
- Disable:
  - Blocks only new loads.
  - A code already presented stays Valid until accepted; after that Valid drops.
  - Pending requests keep accumulating. They are emitted, in round-robin order, after Disable falls.
- Simultaneous events:
  - Accept and load in the same cycle replace Code with no bubble.
  - A request on the line being loaded in the same cycle is absorbed by that load. If that line was also pending, Overrun pulses.
- A line whose code is currently presented (Valid=1) is not pending. A new request on it latches normally and is not an overrun.
- Busy = (pending != 0) | Valid, combinational from registers.

Test Plan:
- Reset with Request=4'b1111 held, then release rst with Ready=1 -> Code 0,1,2,3 on four consecutive cycles with Valid=1; Valid=0 on the 5th cycle once Request is dropped after the first cycle; Overrun=0 throughout.
- Ready=0, pulse Request=4'b0100 for one cycle -> next cycle Valid=1, Code=2; Code and Valid hold for 5 cycles; raise Ready -> Valid=0 on the following edge.
- ptr=2 (after serving line 1), Request=4'b0011 pulsed, Ready=1 -> emits Code=0 then Code=1 (scan starts at 2, wraps to 0).
- Disable=1, pulse Request bits 1 then 3 on separate cycles -> Valid stays 0 and Busy=1; drop Disable -> Code=1 then Code=3 on consecutive cycles.
- Ready=0, Valid=1 with Code=0; pulse Request=4'b0010 twice, two cycles apart -> Overrun=1 for exactly one cycle after the second pulse; line 1 is later emitted once.
- Assert rst asynchronously mid-cycle while Valid=1 and pending=4'b1010 -> Valid, Code, Busy go to 0 immediately without waiting for clk; after release, no stale code is emitted.
